// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding fetched bytes with their source addresses.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head_entry,
  output logic [CNT_W-1:0] count
);
  fetch_entry_t     storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop & (count != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) storage[wr_ptr] <= push_entry;
  end

  // Empty FIFO presents zeros so stale storage never leaks to decode.
  assign head_entry = (count != '0) ? storage[rd_ptr] : '0;

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    (push && !flush) |-> ((count < CNT_W'(DEPTH)) || do_pop));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-based issue to a 1-cycle-latency memory,
// prefetch buffering and branch redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_out_bus,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] issued_pc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              pop;
  logic              issue;
  logic              push;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  assign pop = instr_valid & instr_ready;

  // Slots already promised: buffered + returning next cycle, minus the one leaving.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign issue     = mem_grant & ~redirect & (occupancy < (CNT_W+1)'(DEPTH));
  assign push      = inflight & ~redirect;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) pc <= pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (issue) issued_pc <= pc;
  end

  assign push_entry = '{pc: issued_pc, data: mem_out_bus};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count)
  );

  assign mem_address = pc;
  assign instr_valid = (count != '0);
  assign instr_data  = head_entry.data;
  assign instr_pc    = head_entry.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for start-up/stall, scoreboard for streams.
module tb_fetch_unit;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       mem_grant;
  logic [7:0] mem_address;
  logic [7:0] mem_out_bus;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_data;
  logic [7:0] instr_pc;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];

  typedef struct {
    logic       g;
    logic       r;
    logic       v;
    logic [7:0] pc;
    logic [7:0] addr;
  } vec_t;
  vec_t tbl [14];

  fetch_unit #(.DEPTH(2), .RESET_PC(8'h00)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mem_grant   (mem_grant),
    .mem_address (mem_address),
    .mem_out_bus (mem_out_bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc)
  );

  always #5 clock = ~clock;

  // Registered-read memory: data for an address sampled at an edge appears after it.
  always @(posedge clock) mem_out_bus <= mem[mem_address];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] start, input int n);
    logic [7:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 8'd1;
    end
  endtask

  // Called after inputs are driven at a negedge: a handshake here completes at the next edge.
  task automatic sb_check();
    logic [7:0] e;
    if (instr_valid && instr_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: actual pc %h expected no byte", instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_data", instr_data, e ^ 8'hA5);
      end
    end
  endtask

  task automatic run_stream(input int max_cycles, input bit rand_ready, input bit toggle);
    int n;
    logic [7:0] prev_addr;
    logic       prev_g;
    n = 0;
    prev_addr = 8'h00;
    prev_g = 1'b0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      @(negedge clock);
      if (toggle && n > 0) chk("grant_addr", mem_address, prev_addr + {7'd0, prev_g});
      mem_grant   = toggle ? (n % 2 == 0) : 1'b1;
      instr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_addr   = mem_address;
      prev_g      = mem_grant;
      sb_check();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: actual %0d bytes left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_redirect(input logic [7:0] target, input int n);
    @(negedge clock);
    chk("pre_redirect_valid", {7'd0, instr_valid}, 8'd1);
    redirect    = 1'b1;
    redirect_pc = target;
    mem_grant   = 1'b1;
    instr_ready = 1'($urandom_range(0, 1));
    @(negedge clock);
    chk("post_redirect_valid", {7'd0, instr_valid}, 8'd0);
    chk("post_redirect_addr", mem_address, target);
    redirect    = 1'b0;
    instr_ready = 1'b0;
    exp_q.delete();
    push_exp(target, n);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

    //            g     r     v     pc     addr
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h01};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h02};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h01, 8'h03};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h02, 8'h04};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h03, 8'h05};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h03, 8'h05};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'h03, 8'h05};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h03, 8'h05};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h03, 8'h05};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h03, 8'h05};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 8'h03, 8'h05};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h04, 8'h06};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 8'h05, 8'h07};

    reset_n     = 1'b0;
    mem_grant   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    instr_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_valid", {7'd0, instr_valid}, 8'd0);
    chk("reset_data", instr_data, 8'h00);
    chk("reset_pc", instr_pc, 8'h00);
    chk("reset_addr", mem_address, 8'h00);
    reset_n = 1'b1;

    // Start-up latency, steady stream, 6-cycle stall holding DEPTH entries, release.
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      chk($sformatf("tbl%0d_valid", i), {7'd0, instr_valid}, {7'd0, tbl[i].v});
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_data", i), instr_data, tbl[i].pc ^ 8'hA5);
      end
      chk($sformatf("tbl%0d_addr", i), mem_address, tbl[i].addr);
      mem_grant   = tbl[i].g;
      instr_ready = tbl[i].r;
    end

    // Continue the stream at full rate so a fetch is in flight at the redirect.
    push_exp(8'h06, 8);
    run_stream(100, 1'b0, 1'b0);
    do_redirect(8'h40, 8);
    run_stream(200, 1'b1, 1'b0);

    // Fill the FIFO, then redirect across the 8'hFF -> 8'h00 wrap.
    @(negedge clock);
    instr_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("stall_full_valid", {7'd0, instr_valid}, 8'd1);
    do_redirect(8'hFE, 6);
    run_stream(200, 1'b1, 1'b0);

    // Alternating grant: issue only on granted cycles, stream stays contiguous.
    do_redirect(8'h10, 8);
    run_stream(100, 1'b0, 1'b1);

    // Asynchronous reset between clock edges, mid-stream.
    @(negedge clock);
    mem_grant   = 1'b1;
    instr_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("pre_reset_valid", {7'd0, instr_valid}, 8'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_valid", {7'd0, instr_valid}, 8'd0);
    chk("async_reset_addr", mem_address, 8'h00);
    chk("async_reset_data", instr_data, 8'h00);
    @(posedge clock);
    #3 reset_n = 1'b1;
    exp_q.delete();
    push_exp(8'h00, 8);
    run_stream(200, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running expected finished");
    $fatal(1, "timeout");
  end
endmodule
